// File: rtl/serv_rf_ram_if_np_pkg.sv
`default_nettype none
// serv_rf_ram_if_np_pkg -- shared geometry helpers for the serial RF RAM bridge.
// Revision 1.0
package serv_rf_ram_if_np_pkg;

  localparam int REG_ID_W = 6;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  function automatic int rf_wpr(input int w);
    return 32 / w;
  endfunction

  function automatic int rf_depth(input int w, input int csr_regs);
    return (32 + csr_regs) * (32 / w);
  endfunction

  function automatic int rf_aw(input int w, input int csr_regs);
    return $clog2(rf_depth(w, csr_regs));
  endfunction

endpackage
`default_nettype wire

// File: rtl/serv_rf_ram_if_np_rdbuf.sv
`default_nettype none
// serv_rf_ram_if_np_rdbuf -- one read port: staging word, output shifter and x0 zero mask.
// Revision 1.0
module serv_rf_ram_if_np_rdbuf #(
  parameter int CW = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          cap,
  input  logic          load,
  input  logic          stream,
  input  logic          zero,
  input  logic [W-1:0]  rdata,
  output logic [CW-1:0] data
);

  logic [W-1:0] stage;
  logic [W-1:0] shreg;

  // The last port's word arrives on the same edge it must be loaded, so bypass the stage.
  always_ff @(posedge clk) begin
    if (cap)
      stage <= rdata;
    if (load)
      shreg <= cap ? rdata : stage;
    else if (stream)
      shreg <= shreg >> CW;
  end

  assign data = (stream && !zero) ? shreg[CW-1:0] : '0;

endmodule
`default_nettype wire

// File: rtl/serv_rf_ram_if_np.sv
`default_nettype none
// serv_rf_ram_if_np -- NRP serial read ports and two serial write ports onto a 1R1W RAM.
// Revision 1.0 -- register x0 reads as zero and ignores writes.
module serv_rf_ram_if_np
  import serv_rf_ram_if_np_pkg::*;
#(
  parameter int CW       = 4,
  parameter int NRP      = 2,
  parameter int csr_regs = 4,
  localparam int W       = NRP * CW,
  localparam int AW      = rf_aw(NRP * CW, csr_regs)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rreq,
  input  logic [NRP*REG_ID_W-1:0] i_rreg,
  output logic                    o_ready,
  output logic [NRP*CW-1:0]       o_rdata,
  input  logic                    i_wreq,
  input  logic [REG_ID_W-1:0]     i_wreg0,
  input  logic [REG_ID_W-1:0]     i_wreg1,
  input  logic                    i_wen0,
  input  logic                    i_wen1,
  input  logic [CW-1:0]           i_wdata0,
  input  logic [CW-1:0]           i_wdata1,
  output logic [AW-1:0]           o_waddr,
  output logic [W-1:0]            o_wdata,
  output logic                    o_wen,
  output logic [AW-1:0]           o_raddr,
  output logic                    o_ren,
  input  logic [W-1:0]            i_rdata
);

  localparam int WPR = rf_wpr(W);
  localparam int N   = 32 / CW;
  localparam int SW  = $clog2(NRP);
  localparam int RCW = $clog2(NRP + N + 2);
  localparam int WCW = $clog2(N + 3);

  localparam logic [RCW-1:0] R_ONE   = RCW'(1);
  localparam logic [RCW-1:0] R_TWO   = RCW'(2);
  localparam logic [RCW-1:0] R_N     = RCW'(N);
  localparam logic [RCW-1:0] R_NP1   = RCW'(N + 1);
  localparam logic [RCW-1:0] R_READY = RCW'(NRP + 1);
  localparam logic [RCW-1:0] R_OUT   = RCW'(NRP + 2);
  localparam logic [RCW-1:0] R_LAST  = RCW'(NRP + 1 + N);

  localparam logic [WCW-1:0] W_ONE  = WCW'(1);
  localparam logic [WCW-1:0] W_TWO  = WCW'(2);
  localparam logic [WCW-1:0] W_N    = WCW'(N);
  localparam logic [WCW-1:0] W_LAST = WCW'(N + 2);

  // rcnt holds the cycle number of the read sequence (0 = idle).
  logic [RCW-1:0] rcnt;
  reg_id_t        rreg [NRP];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcnt <= '0;
      for (int p = 0; p < NRP; p++)
        rreg[p] <= '0;
    end else if (rcnt == '0) begin
      if (i_rreq) begin
        rcnt <= R_ONE;
        for (int p = 0; p < NRP; p++)
          rreg[p] <= i_rreg[REG_ID_W*p +: REG_ID_W];
      end
    end else if (rcnt == R_LAST) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  logic [RCW-1:0] ridx;
  logic [RCW-1:0] cidx;
  logic [SW-1:0]  rslot;
  logic [SW-1:0]  cslot;
  logic           cap_win;
  logic           load;
  logic           stream;

  always_comb begin
    ridx    = rcnt - R_ONE;
    cidx    = rcnt - R_TWO;
    rslot   = ridx[SW-1:0];
    cslot   = cidx[SW-1:0];
    o_ren   = (rcnt >= R_ONE) && (rcnt <= R_N);
    o_raddr = AW'(rreg[rslot]) * AW'(WPR) + AW'(ridx >> SW);
    o_ready = (rcnt == R_READY);
    cap_win = (rcnt >= R_TWO) && (rcnt <= R_NP1);
    load    = (rcnt >= R_READY) && (rcnt <= R_NP1) && (rslot == '0);
    stream  = (rcnt >= R_OUT) && (rcnt <= R_LAST);
  end

  generate
    for (genvar p = 0; p < NRP; p++) begin : g_rdport
      serv_rf_ram_if_np_rdbuf #(
        .CW (CW),
        .W  (W)
      ) u_rdbuf (
        .clk    (i_clk),
        .cap    (cap_win && (cslot == SW'(p))),
        .load   (load),
        .stream (stream),
        .zero   (rreg[p] == '0),
        .rdata  (i_rdata),
        .data   (o_rdata[CW*p +: CW])
      );
    end
  endgenerate

  logic [WCW-1:0] wcnt;
  reg_id_t        wreg0;
  reg_id_t        wreg1;
  logic           wen0_pend;
  logic           wen1_mid;
  logic           wen1_pend;
  logic [W-1:0]   acc0;
  logic [W-1:0]   acc1;
  logic [W-1:0]   hold1;
  logic           w_in_seq;
  logic           w_word_end;
  logic [WCW-1:0] wj0;
  logic [WCW-1:0] wj1;

  always_comb begin
    w_in_seq   = (wcnt >= W_ONE) && (wcnt <= W_N);
    w_word_end = w_in_seq && (wcnt[SW-1:0] == '0);
    wj0        = ((wcnt - W_ONE) >> SW) - W_ONE;
    wj1        = ((wcnt - W_TWO) >> SW) - W_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt      <= '0;
      wreg0     <= '0;
      wreg1     <= '0;
      wen0_pend <= 1'b0;
      wen1_mid  <= 1'b0;
      wen1_pend <= 1'b0;
    end else begin
      if (wcnt == '0) begin
        if (i_wreq) begin
          wcnt  <= W_ONE;
          wreg0 <= i_wreg0;
          wreg1 <= i_wreg1;
        end
      end else if (wcnt == W_LAST) begin
        wcnt <= '0;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
      wen0_pend <= w_word_end && i_wen0 && (wreg0 != '0);
      wen1_mid  <= w_word_end && i_wen1 && (wreg1 != '0);
      wen1_pend <= wen1_mid;
    end
  end

  // Port 1 words are delayed one cycle through hold1 so they never share a slot with port 0.
  always_ff @(posedge i_clk) begin
    if (w_in_seq) begin
      acc0 <= {i_wdata0, acc0[W-1:CW]};
      acc1 <= {i_wdata1, acc1[W-1:CW]};
    end
    if (wen1_mid)
      hold1 <= acc1;
  end

  always_comb begin
    o_wen = wen0_pend || wen1_pend;
    if (wen1_pend) begin
      o_waddr = AW'(wreg1) * AW'(WPR) + AW'(wj1);
      o_wdata = hold1;
    end else begin
      o_waddr = AW'(wreg0) * AW'(WPR) + AW'(wj0);
      o_wdata = acc0;
    end
  end

endmodule
`default_nettype wire
